// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default word/FIFO sizes for the serializer and detector benches
package seq_pkg;
    typedef enum logic {IDLE, SHIFT} state_e;
    localparam int SEQ_WIDTH = 8;
    localparam int SEQ_DEPTH = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular word buffer with occupancy count and synchronous clear
module sync_fifo
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int DEPTH = SEQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;
    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    // pointers and occupancy; clear wins over any push or pop in the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop) rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end
    // storage needs no reset: entries are only read after being written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/seq_word_serializer.sv
// seq_word_serializer: buffered parallel-to-serial stage with bit-valid and word-start strobes
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WIDTH,
    parameter int DEPTH     = SEQ_DEPTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             x_out,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CNTW = $clog2(WIDTH);
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shreg_q, shreg_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 frame_q, frame_d;
    logic                 pop, full, empty;
    logic [WIDTH-1:0]     rdata;
    logic [$clog2(DEPTH):0] fifo_count;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (din_valid & din_ready),
        .pop   (pop),
        .clear (flush),
        .wdata (din),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign din_ready   = ~full;
    assign busy        = (fifo_count != '0) | (state_q == SHIFT);
    assign x_valid     = state_q == SHIFT;
    assign x_out       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign frame_start = frame_q;

    // load a new word when idle or on the last bit (gapless reload), otherwise shift; flush aborts everything
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        pop     = 1'b0;
        if (flush) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
        end else if (state_q == IDLE || cnt_q == '0) begin
            if (!empty) begin
                pop     = 1'b1;
                state_d = SHIFT;
                shreg_d = rdata;
                cnt_d   = CNTW'(WIDTH - 1);
                frame_d = 1'b1;
            end else begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        end else begin
            shreg_d = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
            cnt_d   = cnt_q - CNTW'(1);
        end
    end

    // serializer state, shift register and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end
endmodule

// File: tb/tb_seq_word_serializer.sv
// tb_seq_word_serializer: scoreboard bench driving MSB-first and LSB-first serializers in parallel
module tb_seq_word_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       flush = 1'b0;
    logic       din_ready_m, x_out_m, x_valid_m, frame_m, busy_m;
    logic       din_ready_l, x_out_l, x_valid_l, frame_l, busy_l;
    int         n_vec = 0;
    int         n_bad = 0;
    int         stalls = 0;
    logic [1:0] qm[$];
    logic [1:0] ql[$];
    int         run = 0, last_run = 0, frames = 0;
    int         det_st = 0, det_cnt = 0;
    logic       mon_clr = 1'b0;

    always #5 clk = ~clk;

    seq_word_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dm (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_m),
        .flush(flush), .x_out(x_out_m), .x_valid(x_valid_m), .frame_start(frame_m), .busy(busy_m)
    );
    seq_word_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dl (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
        .flush(flush), .x_out(x_out_l), .x_valid(x_valid_l), .frame_start(frame_l), .busy(busy_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int golden110(input logic [7:0] w);
        int n = 0;
        for (int k = 7; k >= 2; k--) if (w[k] && w[k-1] && !w[k-2]) n++;
        return n;
    endfunction

    // expected bits are queued at each accepted transfer; flush discards everything pending
    always @(posedge clk) begin
        if (!rst) begin
            if (flush) begin
                qm.delete();
                ql.delete();
            end else if (din_valid && din_ready_m) begin
                for (int i = 0; i < 8; i++) begin
                    qm.push_back({din[7-i], i == 0});
                    ql.push_back({din[i], i == 0});
                end
            end
        end
    end

    // compare serial output against the scoreboard and track runs, frames and 110 detections
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            qm.delete();
            ql.delete();
        end
        if (mon_clr) begin
            run = 0; last_run = 0; frames = 0; det_st = 0; det_cnt = 0;
        end
        if (x_valid_m) begin
            check("sb_m_avail", qm.size() != 0, 1);
            if (qm.size() != 0) begin
                e = qm.pop_front();
                check("sb_m_bit", x_out_m, e[1]);
                check("sb_m_frame", frame_m, e[0]);
            end
            run++;
            if (frame_m) frames++;
            if (x_out_m) det_st = (det_st == 0) ? 1 : 2;
            else begin
                if (det_st == 2) det_cnt++;
                det_st = 0;
            end
        end else if (run > 0) begin
            last_run = run;
            run = 0;
        end
        if (x_valid_l) begin
            check("sb_l_avail", ql.size() != 0, 1);
            if (ql.size() != 0) begin
                e = ql.pop_front();
                check("sb_l_bit", x_out_l, e[1]);
                check("sb_l_frame", frame_l, e[0]);
            end
        end
    end

    task automatic send(input logic [7:0] w);
        int t = 0;
        din = w;
        din_valid = 1'b1;
        while (!din_ready_m && t < 200) begin
            stalls++;
            @(posedge clk); #1;
            t++;
        end
        check("send_timeout", din_ready_m, 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy_m || busy_l) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("idle_timeout", busy_m | busy_l, 0);
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", din_ready_m, 1);
        check("rst_ready_l", din_ready_l, 1);
        check("rst_xout", x_out_m, 0);
        check("rst_xvalid", x_valid_m, 0);
        check("rst_frame", frame_m, 0);
        check("rst_busy", busy_m, 0);

        clear_mon();
        @(posedge clk); #1;
        send(8'b0110_1100);
        wait_idle();
        check("single_run", last_run, 8);
        check("single_frames", frames, 1);

        clear_mon();
        @(posedge clk); #1;
        send(8'hA5);
        send(8'h3C);
        wait_idle();
        check("b2b_run", last_run, 16);
        check("b2b_frames", frames, 2);

        clear_mon();
        @(posedge clk); #1;
        stalls = 0;
        for (int i = 0; i < 10; i++) send(8'(i * 37 + 11));
        check("burst_stalled", stalls > 0, 1);
        wait_idle();
        check("burst_run", last_run, 80);
        check("burst_frames", frames, 10);

        @(posedge clk); #1;
        send(8'h81);
        send(8'h42);
        send(8'h24);
        @(posedge clk); #1;
        check("pre_flush_xv", x_valid_m, 1);
        flush = 1'b1;
        din = 8'hEE;
        din_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        din_valid = 1'b0;
        check("flush_xvalid", x_valid_m, 0);
        check("flush_xout", x_out_m, 0);
        check("flush_frame", frame_m, 0);
        check("flush_busy", busy_m, 0);
        check("flush_ready", din_ready_m, 1);
        @(posedge clk); #1;
        check("flush_drop", busy_m, 0);
        clear_mon();
        send(8'hFF);
        wait_idle();
        check("ff_run", last_run, 8);
        check("ff_det", det_cnt, 0);

        @(posedge clk); #1;
        send(8'hFF);
        @(posedge clk); #1;
        check("pre_rst_xv", x_valid_m, 1);
        check("pre_rst_xo", x_out_m, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_xout", x_out_m, 0);
        check("arst_xvalid", x_valid_m, 0);
        check("arst_frame", frame_m, 0);
        check("arst_busy", busy_m, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", din_ready_m, 1);
        check("post_rst_busy", busy_m, 0);
        check("post_rst_xv", x_valid_m, 0);

        clear_mon();
        send(8'b1101_1000);
        wait_idle();
        check("det110", det_cnt, golden110(8'b1101_1000));

        check("sb_m_left", qm.size(), 0);
        check("sb_l_left", ql.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
